instr_fetch: RTL and testbench

//  Instruction fetch stage of the single-cycle MIPS core; feeds the opcode/funct decoder and register file.

---
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, next-PC resolution, ROM addressing, sticky fault trap.
module instr_fetch #(
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               Jr,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Zero,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        Read_data_1,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        Instruction,
  output logic [31:0]        branch_base_addr,
  output logic [31:0]        link_addr,
  output logic [31:0]        pc_out,
  output logic               fetch_fault,
  output logic [31:0]        instr_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q;
  logic        fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        bad_target;
  logic        fault_now;
  logic        retire;

  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    Instruction = (reset || state_q == HALT) ? 32'h0 : imem_data;

    if (Jr)
      target = Read_data_1;
    else if (Jmp || Jal)
      target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
    else if ((Branch && Zero) || (nBranch && !Zero))
      target = Addr_result;
    else
      target = pc_plus4;

    // Misaligned, or beyond ROM depth (this also catches a PC+4 that runs off the end).
    bad_target = (target[1:0] != 2'b00) || ((target >> (IMEM_AW + 2)) != 32'd0);
    fault_now  = !reset && state_q == RUN && !stall && bad_target;
    retire     = !reset && state_q == RUN && !stall && !bad_target;

    if (reset)
      pc_d = RESET_PC;
    else if (state_q == HALT || stall || fault_now)
      pc_d = pc_q;
    else
      pc_d = target;
  end

  // ROM samples this address on the same edge that loads pc_d, so Instruction tracks PC with no bubble.
  assign imem_addr        = pc_d[IMEM_AW+1:2];
  assign branch_base_addr = pc_plus4;
  assign link_addr        = pc_plus4;
  assign pc_out           = pc_q;
  assign fetch_fault      = fault_q;
  assign instr_count      = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (fault_now) begin
        state_q <= HALT;
        fault_q <= 1'b1;
      end
      if (retire)
        count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch with a synchronous ROM model.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset, stall, Jr, Jmp, Jal, Branch, nBranch, Zero;
  logic [31:0] Addr_result, Read_data_1;
  logic [13:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] Instruction, branch_base_addr, link_addr, pc_out, instr_count;
  logic        fetch_fault;

  logic [31:0] rom [0:16383];

  int checks   = 0;
  int failures = 0;

  instr_fetch #(.IMEM_AW(14), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .Jr(Jr), .Jmp(Jmp), .Jal(Jal), .Branch(Branch), .nBranch(nBranch), .Zero(Zero),
    .Addr_result(Addr_result), .Read_data_1(Read_data_1),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .Instruction(Instruction), .branch_base_addr(branch_base_addr), .link_addr(link_addr),
    .pc_out(pc_out), .fetch_fault(fetch_fault), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= rom[imem_addr];

  typedef struct {
    logic        st, jr, jmp, jal, br, nbr, z;
    logic [31:0] addr, rd1;
    logic [31:0] e_pc, e_cnt;
  } vec_t;

  vec_t vecs [0:17];

  function automatic vec_t mk(logic st, logic jr, logic jmp, logic jal, logic br, logic nbr,
                              logic z, logic [31:0] addr, logic [31:0] rd1,
                              logic [31:0] e_pc, logic [31:0] e_cnt);
    vec_t v;
    v.st = st; v.jr = jr; v.jmp = jmp; v.jal = jal; v.br = br; v.nbr = nbr; v.z = z;
    v.addr = addr; v.rd1 = rd1; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.st; Jr = v.jr; Jmp = v.jmp; Jal = v.jal;
    Branch = v.br; nBranch = v.nbr; Zero = v.z;
    Addr_result = v.addr; Read_data_1 = v.rd1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic hold_stall);
    drive(mk(hold_stall, 0, 1, 0, 1, 0, 1, 32'h40, 32'h44, 0, 0));
    reset = 1'b1;
    tick();
    tick();
    check("rst_instr", Instruction, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_cnt", instr_count, 32'h0);
    check("rst_fault", {31'd0, fetch_fault}, 32'h0);
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_rst_pc", pc_out, 32'h0);
    check("post_rst_instr", Instruction, 32'h2008_0005);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 32'h2400_0000 | i;
    rom[0]  = 32'h2008_0005;
    rom[1]  = 32'h2009_0007;
    rom[8]  = 32'h0C00_0030;
    rom[65] = 32'h0800_0010;

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'h4,   1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'h8,   2);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'hC,   3);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'h10,  4);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h40, 0,     32'h14,  5);
    vecs[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0,     32'h10, 32'h10,  6);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 32'h40, 0,     32'h40,  7);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h18, 0,     32'h18,  8);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h80, 0,     32'h1C,  9);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'h20,  10);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 0, 0,     0,      32'hC0,  11);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0,     32'h24, 32'h24,  12);
    vecs[12] = mk(0, 1, 1, 0, 1, 0, 1, 32'h40, 32'h100, 32'h100, 13);
    vecs[13] = mk(1, 0, 1, 0, 0, 0, 0, 0,     0,      32'h100, 13);
    vecs[14] = mk(1, 0, 1, 0, 0, 0, 0, 0,     0,      32'h100, 13);
    vecs[15] = mk(1, 0, 1, 0, 0, 0, 0, 0,     0,      32'h100, 13);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,     0,      32'h104, 14);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 0, 0,     0,      32'h40,  15);

    do_reset(1'b0);
    check("link_at_0", link_addr, 32'h4);

    for (int i = 0; i < 18; i++) begin
      // Jal cycle: return address must be visible before the jump edge.
      if (vecs[i].jal) begin
        drive(vecs[i]);
        #1;
        check("jal_link", link_addr, 32'h24);
        check("jal_base", branch_base_addr, 32'h24);
      end
      drive(vecs[i]);
      tick();
      check($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), Instruction, rom[vecs[i].e_pc[15:2]]);
      check($sformatf("v%0d_cnt", i), instr_count, vecs[i].e_cnt);
      check($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, 32'h0);
      check($sformatf("v%0d_link", i), link_addr, vecs[i].e_pc + 32'd4);
    end

    // Misaligned Jr target traps; PC holds and HALT ignores later controls.
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h22, 0, 0));
    tick();
    check("mis_fault", {31'd0, fetch_fault}, 32'h1);
    check("mis_pc", pc_out, 32'h40);
    check("mis_instr", Instruction, 32'h0);
    check("mis_cnt", instr_count, 32'd15);
    drive(mk(0, 0, 1, 0, 1, 0, 1, 32'h80, 0, 0, 0));
    tick();
    tick();
    check("halt_pc", pc_out, 32'h40);
    check("halt_fault", {31'd0, fetch_fault}, 32'h1);
    check("halt_instr", Instruction, 32'h0);
    check("halt_cnt", instr_count, 32'd15);

    do_reset(1'b1);

    // Jr priority still applies to an out-of-range target.
    drive(mk(0, 1, 1, 0, 1, 0, 1, 32'h40, 32'h0001_0000, 0, 0));
    tick();
    check("oor_fault", {31'd0, fetch_fault}, 32'h1);
    check("oor_pc", pc_out, 32'h0);
    check("oor_cnt", instr_count, 32'h0);

    do_reset(1'b0);

    // Last ROM word is legal; falling off its end is not.
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0000_FFFC, 0, 0));
    tick();
    check("last_pc", pc_out, 32'h0000_FFFC);
    check("last_instr", Instruction, rom[16383]);
    check("last_fault", {31'd0, fetch_fault}, 32'h0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("wrap_fault", {31'd0, fetch_fault}, 32'h1);
    check("wrap_pc", pc_out, 32'h0000_FFFC);
    check("wrap_cnt", instr_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
